// File: rtl/text_cursor_writer.sv
// Cursor-driven single-cell writer for a 7x20 character plane; one code per 2 cycles, char_ready low while executing/clearing.
// Define CLEAR_ON_WRAP_EN to blank each newly entered row (CLR_ROW) after a line wrap or LF.
module text_cursor_writer #(
  parameter int ROW_NUMBER  = 7,
  parameter int COL_NUMBER  = 20,
  parameter int ROW_BIT_LEN = 4,
  parameter int COL_BIT_LEN = 6,
  parameter int BLANK_ID    = 129
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic                   char_ready,
  output logic [7:0]             wr_data,
  output logic [ROW_BIT_LEN-1:0] wr_row,
  output logic [COL_BIT_LEN-1:0] wr_col,
  output logic                   wr_we,
  output logic                   wr_push_up,
  output logic [ROW_BIT_LEN-1:0] cursor_row,
  output logic [COL_BIT_LEN-1:0] cursor_col,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_CLR_ALL,
    S_IDLE,
    S_EXEC
`ifdef CLEAR_ON_WRAP_EN
    , S_CLR_ROW
`endif
  } state_t;

`ifdef CLEAR_ON_WRAP_EN
  localparam state_t ROW_ADV_NEXT = S_CLR_ROW;
`else
  localparam state_t ROW_ADV_NEXT = S_IDLE;
`endif

  localparam logic [ROW_BIT_LEN-1:0] LAST_ROW = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LAST_COL = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [7:0]             BLANK    = 8'(BLANK_ID);

  state_t                 r_state, w_state;
  state_t                 r_after_exec, w_after_exec;
  logic                   r_wr_we, w_wr_we;
  logic [7:0]             r_wr_data, w_wr_data;
  logic [ROW_BIT_LEN-1:0] r_wr_row, w_wr_row;
  logic [COL_BIT_LEN-1:0] r_wr_col, w_wr_col;
  logic [ROW_BIT_LEN-1:0] r_cur_row, w_cur_row;
  logic [COL_BIT_LEN-1:0] r_cur_col, w_cur_col;
  logic [ROW_BIT_LEN-1:0] w_adv_row;

  assign w_adv_row = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + 1'b1;

  // wr_* are registered: each edge loads what the upcoming cycle presents to the plane.
  always_comb begin
    w_state      = r_state;
    w_after_exec = r_after_exec;
    w_wr_we      = 1'b0;
    w_wr_data    = BLANK;
    w_wr_row     = r_wr_row;
    w_wr_col     = r_wr_col;
    w_cur_row    = r_cur_row;
    w_cur_col    = r_cur_col;
    case (r_state)
      S_CLR_ALL: begin
        w_wr_we = 1'b1;
        if (!r_wr_we) begin
          w_wr_row = '0;
          w_wr_col = '0;
        end else if (r_wr_row == LAST_ROW && r_wr_col == LAST_COL) begin
          w_wr_we = 1'b0;
          w_state = S_IDLE;
        end else if (r_wr_col == LAST_COL) begin
          w_wr_row = r_wr_row + 1'b1;
          w_wr_col = '0;
        end else begin
          w_wr_col = r_wr_col + 1'b1;
        end
      end
      S_IDLE: begin
        if (char_valid) begin
          w_state      = S_EXEC;
          w_after_exec = S_IDLE;
          case (char_in)
            8'h0D: w_cur_col = '0;
            8'h0A: begin
              w_cur_col    = '0;
              w_cur_row    = w_adv_row;
              w_after_exec = ROW_ADV_NEXT;
            end
            8'h08: begin
              if (r_cur_col != '0) begin
                w_wr_we   = 1'b1;
                w_wr_row  = r_cur_row;
                w_wr_col  = r_cur_col - 1'b1;
                w_cur_col = r_cur_col - 1'b1;
              end else if (r_cur_row != '0) begin
                w_wr_we   = 1'b1;
                w_wr_row  = r_cur_row - 1'b1;
                w_wr_col  = LAST_COL;
                w_cur_row = r_cur_row - 1'b1;
                w_cur_col = LAST_COL;
              end
            end
            8'h0C: begin
              w_cur_row    = '0;
              w_cur_col    = '0;
              w_after_exec = S_CLR_ALL;
            end
            default: begin
              w_wr_we   = 1'b1;
              w_wr_data = char_in;
              w_wr_row  = r_cur_row;
              w_wr_col  = r_cur_col;
              if (r_cur_col == LAST_COL) begin
                w_cur_col    = '0;
                w_cur_row    = w_adv_row;
                w_after_exec = ROW_ADV_NEXT;
              end else begin
                w_cur_col = r_cur_col + 1'b1;
              end
            end
          endcase
        end
      end
      S_EXEC: begin
        w_state = r_after_exec;
        // Both clears start at (cursor_row, 0); a form feed has already homed the cursor.
        if (r_after_exec != S_IDLE) begin
          w_wr_we  = 1'b1;
          w_wr_row = r_cur_row;
          w_wr_col = '0;
        end
      end
`ifdef CLEAR_ON_WRAP_EN
      S_CLR_ROW: begin
        if (r_wr_col == LAST_COL) begin
          w_state = S_IDLE;
        end else begin
          w_wr_we  = 1'b1;
          w_wr_col = r_wr_col + 1'b1;
        end
      end
`endif
      default: w_state = S_CLR_ALL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_CLR_ALL;
      r_after_exec <= S_IDLE;
      r_wr_we      <= 1'b0;
      r_wr_data    <= BLANK;
      r_wr_row     <= '0;
      r_wr_col     <= '0;
      r_cur_row    <= '0;
      r_cur_col    <= '0;
    end else begin
      r_state      <= w_state;
      r_after_exec <= w_after_exec;
      r_wr_we      <= w_wr_we;
      r_wr_data    <= w_wr_data;
      r_wr_row     <= w_wr_row;
      r_wr_col     <= w_wr_col;
      r_cur_row    <= w_cur_row;
      r_cur_col    <= w_cur_col;
    end
  end

  assign char_ready = (r_state == S_IDLE);
`ifdef CLEAR_ON_WRAP_EN
  assign busy       = (r_state == S_CLR_ALL) || (r_state == S_CLR_ROW);
`else
  assign busy       = (r_state == S_CLR_ALL);
`endif
  assign wr_we      = r_wr_we;
  assign wr_data    = r_wr_data;
  assign wr_row     = r_wr_row;
  assign wr_col     = r_wr_col;
  assign wr_push_up = 1'b0;
  assign cursor_row = r_cur_row;
  assign cursor_col = r_cur_col;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Directed table-driven bench for text_cursor_writer: reset clear, codes, wraps, backspace, mid-clear reset.
module tb_text_cursor_writer;

  localparam int COLS = 20;
  localparam int CELLS = 140;
`ifdef CLEAR_ON_WRAP_EN
  localparam int ROWCLR = 20;
`else
  localparam int ROWCLR = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic [7:0] wr_data;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic       wr_we;
  logic       wr_push_up;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;
  logic       busy;

  int total = 0;
  int bad = 0;

  text_cursor_writer dut (
    .clock(clock), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .wr_data(wr_data), .wr_row(wr_row), .wr_col(wr_col),
    .wr_we(wr_we), .wr_push_up(wr_push_up), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] code;
    bit         we;
    logic [7:0] dat;
    int         wr, wc;
    int         cr, cc;
    bit         adv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; runs until char_ready, checking every blank write.
  task automatic wait_ready(input string nm, input int exp_writes, input int fixed_row, input int exp_low);
    int n = 0;
    int k = 0;
    bit seq_ok = 1'b1;
    while (!char_ready && n < 400) begin
      if (wr_we) begin
        int er, ec;
        if (fixed_row < 0) begin
          er = k / COLS;
          ec = k % COLS;
        end else begin
          er = fixed_row;
          ec = k;
        end
        if (wr_data !== 8'd129 || wr_row !== 4'(er) || wr_col !== 6'(ec)) seq_ok = 1'b0;
        k++;
      end
      n++;
      @(negedge clock);
    end
    chk({nm, "_ready"}, 32'(char_ready), 1);
    chk({nm, "_writes"}, k, exp_writes);
    chk({nm, "_low_cycles"}, n, exp_low);
    chk({nm, "_seq"}, 32'(seq_ok), 1);
  endtask

  task automatic send(input string nm, input logic [7:0] c, input bit e_we, input logic [7:0] e_dat,
                      input int e_r, input int e_c, input int cr, input int cc,
                      input int extra, input int fixed_row);
    chk({nm, "_rdy_before"}, 32'(char_ready), 1);
    char_in = c;
    char_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    char_valid = 1'b0;
    char_in = 8'h00;
    chk({nm, "_rdy_exec"}, 32'(char_ready), 0);
    chk({nm, "_we"}, 32'(wr_we), 32'(e_we));
    chk({nm, "_data"}, 32'(wr_data), 32'(e_dat));
    if (e_we) begin
      chk({nm, "_wrow"}, 32'(wr_row), e_r);
      chk({nm, "_wcol"}, 32'(wr_col), e_c);
    end
    @(negedge clock);
    wait_ready(nm, extra, fixed_row, extra);
    chk({nm, "_cur_row"}, 32'(cursor_row), cr);
    chk({nm, "_cur_col"}, 32'(cursor_col), cc);
  endtask

  vec_t vec[15];

  initial begin
    vec[0]  = '{8'h41, 1'b1, 8'h41,  0,  0, 0,  1, 1'b0};
    vec[1]  = '{8'h0D, 1'b0, 8'd129, 0,  0, 0,  0, 1'b0};
    vec[2]  = '{8'h08, 1'b0, 8'd129, 0,  0, 0,  0, 1'b0};
    vec[3]  = '{8'h0A, 1'b0, 8'd129, 0,  0, 1,  0, 1'b1};
    vec[4]  = '{8'h08, 1'b1, 8'd129, 0, 19, 0, 19, 1'b0};
    vec[5]  = '{8'h5A, 1'b1, 8'h5A,  0, 19, 1,  0, 1'b1};
    vec[6]  = '{8'hFF, 1'b1, 8'hFF,  1,  0, 1,  1, 1'b0};
    vec[7]  = '{8'h08, 1'b1, 8'd129, 1,  0, 1,  0, 1'b0};
    vec[8]  = '{8'h0A, 1'b0, 8'd129, 0,  0, 2,  0, 1'b1};
    vec[9]  = '{8'h0A, 1'b0, 8'd129, 0,  0, 3,  0, 1'b1};
    vec[10] = '{8'h0A, 1'b0, 8'd129, 0,  0, 4,  0, 1'b1};
    vec[11] = '{8'h0A, 1'b0, 8'd129, 0,  0, 5,  0, 1'b1};
    vec[12] = '{8'h0A, 1'b0, 8'd129, 0,  0, 6,  0, 1'b1};
    vec[13] = '{8'h43, 1'b1, 8'h43,  6,  0, 6,  1, 1'b0};
    vec[14] = '{8'h0A, 1'b0, 8'd129, 0,  0, 0,  0, 1'b1};

    // Reset state and power-up clear
    repeat (2) @(negedge clock);
    chk("rst_we", 32'(wr_we), 0);
    chk("rst_data", 32'(wr_data), 129);
    chk("rst_wrow", 32'(wr_row), 0);
    chk("rst_wcol", 32'(wr_col), 0);
    chk("rst_push", 32'(wr_push_up), 0);
    chk("rst_cur", {cursor_row, cursor_col}, 0);
    chk("rst_ready", 32'(char_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    reset = 1'b0;
    @(negedge clock);
    wait_ready("clr", CELLS, -1, CELLS);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_cur", {cursor_row, cursor_col}, 0);

    for (int i = 0; i < 15; i++) begin
      send($sformatf("vec%0d", i), vec[i].code, vec[i].we, vec[i].dat, vec[i].wr, vec[i].wc,
           vec[i].cr, vec[i].cc, vec[i].adv ? ROWCLR : 0, vec[i].cr);
    end

    // Line wrap across row 0
    for (int i = 0; i < COLS; i++) begin
      send($sformatf("wrap%0d", i), 8'h42, 1'b1, 8'h42, 0, i,
           (i == COLS - 1) ? 1 : 0, (i == COLS - 1) ? 0 : i + 1,
           (i == COLS - 1) ? ROWCLR : 0, 1);
    end

    // Form feed: full clear, cursor home
    send("ff", 8'h0C, 1'b0, 8'd129, 0, 0, 0, 0, CELLS, -1);

    // Reset during cycle 50 of a form-feed clear
    send("pre", 8'h41, 1'b1, 8'h41, 0, 0, 0, 1, 0, 0);
    char_in = 8'h0C;
    char_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    char_valid = 1'b0;
    repeat (50) @(negedge clock);
    chk("mid_we", 32'(wr_we), 1);
    chk("mid_wrow", 32'(wr_row), 2);
    chk("mid_wcol", 32'(wr_col), 9);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_rst_we", 32'(wr_we), 0);
    chk("mid_rst_busy", 32'(busy), 1);
    chk("mid_rst_ready", 32'(char_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    wait_ready("mid_clr", CELLS, -1, CELLS);
    chk("mid_cur", {cursor_row, cursor_col}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
